// File: rtl/slv_responder_pkg.sv
// ---------------------------------------------------------------------------
// slv_responder_pkg
//   Shared types for the master/slave bus as seen by the slave endpoint:
//     t_mst - request from the crossbar (valid, we, addr, wdata)
//     t_slv - response to the crossbar (ready, rvalid, rdata, err)
//     t_st  - slave protocol phase, used by the crossbar for time-sharing
//   The crossbar switches at the CMD and ADDR phases. IDLE, DATA and RESP
//   complete the slave-side transaction sequence.
//   addr_bad() is the address decode shared by the RTL.
// ---------------------------------------------------------------------------
package slv_responder_pkg;

    typedef struct packed {
        logic        valid;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } t_mst;

    typedef struct packed {
        logic        ready;
        logic        rvalid;
        logic [31:0] rdata;
        logic        err;
    } t_slv;

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        ADDR,
        DATA,
        RESP
    } t_st;

    // A request is bad when it targets the other slave, has non-zero bits
    // above the word index (there is no index wrap), or is not word aligned.
    function automatic logic addr_bad(logic [31:0] addr, logic slv_id, int aw);
        logic [31:0] hi_mask;
        hi_mask = (32'h7FFF_FFFF >> (aw + 2)) << (aw + 2);
        return (addr[31] != slv_id) || ((addr & hi_mask) != 32'h0) ||
               (addr[1:0] != 2'b00);
    endfunction

endpackage

// File: rtl/slv_responder_if.sv
// ---------------------------------------------------------------------------
// slv_responder_if
//   Bundle between one crossbar output and the slave endpoint.
//     mst_in  - request, driven by the master side
//     slv_out - response, driven by the slave side
//     st      - slave protocol phase, driven by the slave side
//   Modports: master (crossbar side), slave (slv_responder side).
// ---------------------------------------------------------------------------
interface slv_responder_if;
    import slv_responder_pkg::*;

    t_mst mst_in;
    t_slv slv_out;
    t_st  st;

    modport master (output mst_in, input slv_out, input st);
    modport slave  (input mst_in, output slv_out, output st);

endinterface

// File: rtl/slv_ram.sv
// ---------------------------------------------------------------------------
// slv_ram
//   Single-port synchronous RAM, 2**AW x 32 bits, one-cycle read latency,
//   write-first (a write returns the written word on rdata).
//   Ports:
//     clk   - clock, rising edge
//     en    - access enable for this cycle
//     we    - 1 = write, 0 = read (when en)
//     idx   - word index
//     wdata - write data
//     rdata - read data, valid the cycle after a read or write access
// ---------------------------------------------------------------------------
module slv_ram #(
    parameter int AW = 8
) (
    input  logic          clk,
    input  logic          en,
    input  logic          we,
    input  logic [AW-1:0] idx,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem [0:(1 << AW) - 1];

    // NOTE: the memory array and its read register carry no reset, so the
    // block maps onto a RAM macro and contents survive a reset pulse.
    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                mem[idx] <= wdata;
                rdata    <= wdata;
            end else begin
                rdata    <= mem[idx];
            end
        end
    end

endmodule

// File: rtl/slv_responder.sv
// ---------------------------------------------------------------------------
// slv_responder
//   Slave endpoint behind one crossbar output. Accepts a single-beat request
//   in IDLE, walks CMD -> ADDR -> DATA -> RESP, and returns one response with
//   rvalid for exactly one cycle. Requests arriving while busy are dropped.
//   Parameters:
//     SLV_ID     - value of addr[31] owned by this slave
//     AW         - word-index width, memory depth 2**AW words
//     INIT_RDATA - rdata returned with err
//   Ports:
//     clk   - clock, rising edge
//     rst_n - asynchronous active-low reset
//     bus   - slave modport: mst_in (request), slv_out (response), st (phase)
// ---------------------------------------------------------------------------
module slv_responder
    import slv_responder_pkg::*;
#(
    parameter logic        SLV_ID     = 1'b0,
    parameter int          AW         = 8,
    parameter logic [31:0] INIT_RDATA = 32'hDEAD_BEEF
) (
    input logic            clk,
    input logic            rst_n,
    slv_responder_if.slave bus
);

    t_st           state_q, state_d;
    t_slv          out_q, out_d;

    logic          we_q;
    logic [31:0]   addr_q;
    logic [31:0]   wdata_q;
    logic          cmd_we_q;
    logic          bad_q;
    logic [AW-1:0] idx_q;

    logic          ram_en;
    logic [31:0]   ram_rdata;

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values of its neighbours.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Outputs are registered: the action taken in a phase becomes visible
    // the cycle after the edge that leaves that phase, so rvalid coincides
    // with the return to IDLE and ready follows the next state.
    // NOTE: every signal written here gets a default first, which keeps
    // this block free of inferred latches.
    always_comb begin
        state_d      = state_q;
        out_d        = out_q;
        out_d.rvalid = 1'b0;
        unique case (state_q)
            IDLE: if (bus.mst_in.valid) state_d = CMD;
            CMD:  state_d = ADDR;
            ADDR: state_d = DATA;
            DATA: state_d = RESP;
            RESP: begin
                state_d      = IDLE;
                out_d.rvalid = 1'b1;
                out_d.err    = bad_q;
                if (bad_q) begin
                    out_d.rdata = INIT_RDATA;
                end else if (cmd_we_q) begin
                    out_d.rdata = wdata_q;
                end else begin
                    out_d.rdata = ram_rdata;
                end
            end
            default: state_d = IDLE;
        endcase
        out_d.ready = (state_d == IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q <= '{ready: 1'b1, rvalid: 1'b0, rdata: 32'h0, err: 1'b0};
        end else begin
            out_q <= out_d;
        end
    end

    // Request capture and decode. mst_in is only looked at in IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_q     <= 1'b0;
            addr_q   <= 32'h0;
            wdata_q  <= 32'h0;
            cmd_we_q <= 1'b0;
            bad_q    <= 1'b0;
            idx_q    <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (bus.mst_in.valid) begin
                        we_q    <= bus.mst_in.we;
                        addr_q  <= bus.mst_in.addr;
                        wdata_q <= bus.mst_in.wdata;
                    end
                end
                CMD:  cmd_we_q <= we_q;
                ADDR: begin
                    bad_q <= addr_bad(addr_q, SLV_ID, AW);
                    idx_q <= addr_q[AW+1:2];
                end
                default: ;
            endcase
        end
    end

    // The RAM access fires on the edge leaving DATA; read data is then
    // available throughout RESP. Reset forces IDLE, so a pending write that
    // has not reached that edge never happens.
    assign ram_en = (state_q == DATA) && !bad_q;

    slv_ram #(.AW(AW)) u_ram (
        .clk   (clk),
        .en    (ram_en),
        .we    (cmd_we_q),
        .idx   (idx_q),
        .wdata (wdata_q),
        .rdata (ram_rdata)
    );

    assign bus.slv_out = out_q;
    assign bus.st      = state_q;

endmodule

// File: tb/tb_slv_responder.sv
module tb_slv_responder;
    import slv_responder_pkg::*;

    localparam logic [31:0] E = 32'hDEAD_BEEF;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    slv_responder_if bus ();

    slv_responder #(.SLV_ID(1'b0), .AW(8), .INIT_RDATA(E)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_vec = 0;
    int n_bad = 0;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } t_exp;
    t_exp exp_q[$];

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        err;
    } t_vec;
    t_vec vecs [17];

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Scoreboard: every response is matched against the oldest expectation.
    always @(negedge clk) begin
        if (rst_n && bus.slv_out.rvalid === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_rvalid", 32'd1, 32'd0);
            end else begin
                t_exp e;
                e = exp_q.pop_front();
                check("rdata", bus.slv_out.rdata, e.rdata);
                check("err", 32'(bus.slv_out.err), 32'(e.err));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One transaction with full phase/latency checking. With inject set, a
    // write to 0x20 is held on mst_in during CMD and must be dropped.
    task automatic txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [31:0] exp_rdata, input logic exp_err, input logic inject);
        int w = 0;
        while (bus.slv_out.ready !== 1'b1 && w < 20) begin
            step();
            w++;
        end
        check("ready_idle", 32'(bus.slv_out.ready), 32'd1);
        bus.mst_in = '{valid: 1'b1, we: we, addr: addr, wdata: wdata};
        exp_q.push_back('{rdata: exp_rdata, err: exp_err});
        step();
        if (inject) bus.mst_in = '{valid: 1'b1, we: 1'b1, addr: 32'h20, wdata: 32'hAAAA_AAAA};
        else bus.mst_in.valid = 1'b0;
        check("st_cmd", 32'(bus.st), 32'(CMD));
        check("ready_busy", 32'(bus.slv_out.ready), 32'd0);
        step();
        bus.mst_in.valid = 1'b0;
        check("st_addr", 32'(bus.st), 32'(ADDR));
        step();
        check("st_data", 32'(bus.st), 32'(DATA));
        step();
        check("st_resp", 32'(bus.st), 32'(RESP));
        check("rvalid_early", 32'(bus.slv_out.rvalid), 32'd0);
        step();
        check("st_idle", 32'(bus.st), 32'(IDLE));
        check("rvalid_5th", 32'(bus.slv_out.rvalid), 32'd1);
        check("ready_back", 32'(bus.slv_out.ready), 32'd1);
        step();
        check("rvalid_pulse", 32'(bus.slv_out.rvalid), 32'd0);
    endtask

    task automatic check_reset_state(string tag);
        check({tag, "_st"}, 32'(bus.st), 32'(IDLE));
        check({tag, "_ready"}, 32'(bus.slv_out.ready), 32'd1);
        check({tag, "_rvalid"}, 32'(bus.slv_out.rvalid), 32'd0);
        check({tag, "_err"}, 32'(bus.slv_out.err), 32'd0);
        check({tag, "_rdata"}, bus.slv_out.rdata, 32'h0);
    endtask

    initial begin
        vecs[0]  = '{1'b1, 32'h0000_0010, 32'h1234_5678, 32'h1234_5678, 1'b0};
        vecs[1]  = '{1'b0, 32'h0000_0010, 32'h0,         32'h1234_5678, 1'b0};
        vecs[2]  = '{1'b1, 32'h8000_0010, 32'h5555_AAAA, E,             1'b1};
        vecs[3]  = '{1'b0, 32'h0000_0010, 32'h0,         32'h1234_5678, 1'b0};
        vecs[4]  = '{1'b0, 32'h0000_0012, 32'h0,         E,             1'b1};
        vecs[5]  = '{1'b0, 32'h0000_0400, 32'h0,         E,             1'b1};
        vecs[6]  = '{1'b1, 32'h0000_0000, 32'h0101_0101, 32'h0101_0101, 1'b0};
        vecs[7]  = '{1'b1, 32'h0000_0400, 32'h9999_9999, E,             1'b1};
        vecs[8]  = '{1'b0, 32'h0000_0000, 32'h0,         32'h0101_0101, 1'b0};
        vecs[9]  = '{1'b1, 32'h0000_03FC, 32'hCAFE_F00D, 32'hCAFE_F00D, 1'b0};
        vecs[10] = '{1'b0, 32'h0000_03FC, 32'h0,         32'hCAFE_F00D, 1'b0};
        vecs[11] = '{1'b1, 32'h0000_0020, 32'h1111_2222, 32'h1111_2222, 1'b0};
        vecs[12] = '{1'b1, 32'h0000_0030, 32'h3333_4444, 32'h3333_4444, 1'b0};
        vecs[13] = '{1'b1, 32'h0000_0031, 32'h7777_7777, E,             1'b1};
        vecs[14] = '{1'b0, 32'h0000_0030, 32'h0,         32'h3333_4444, 1'b0};
        vecs[15] = '{1'b1, 32'h4000_0030, 32'h8888_8888, E,             1'b1};
        vecs[16] = '{1'b0, 32'h0000_0030, 32'h0,         32'h3333_4444, 1'b0};

        // Reset held for 3 cycles with a request pending on the bus.
        bus.mst_in = '{valid: 1'b1, we: 1'b1, addr: 32'h10, wdata: 32'hFFFF_FFFF};
        rst_n = 1'b0;
        repeat (3) begin
            step();
            check_reset_state("rst0");
        end
        bus.mst_in.valid = 1'b0;
        rst_n = 1'b1;
        step();

        foreach (vecs[i])
            txn(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].rdata, vecs[i].err, 1'b0);

        // Busy drop: a write offered during CMD must not land in mem[8].
        txn(1'b0, 32'h20, 32'h0, 32'h1111_2222, 1'b0, 1'b1);
        repeat (3) step();
        txn(1'b0, 32'h20, 32'h0, 32'h1111_2222, 1'b0, 1'b0);

        // Mid-op reset during CMD of a write: no response, mem[12] kept.
        bus.mst_in = '{valid: 1'b1, we: 1'b1, addr: 32'h30, wdata: 32'h5555_6666};
        step();
        bus.mst_in.valid = 1'b0;
        check("midrst_cmd", 32'(bus.st), 32'(CMD));
        rst_n = 1'b0;
        #1;
        check("midrst_st", 32'(bus.st), 32'(IDLE));
        check("midrst_ready", 32'(bus.slv_out.ready), 32'd1);
        check("midrst_rvalid", 32'(bus.slv_out.rvalid), 32'd0);
        step();
        rst_n = 1'b1;
        repeat (6) step();
        check("midrst_idle", 32'(bus.st), 32'(IDLE));
        txn(1'b0, 32'h30, 32'h0, 32'h3333_4444, 1'b0, 1'b0);

        // Reset with a pending write must leave memory untouched.
        bus.mst_in = '{valid: 1'b1, we: 1'b1, addr: 32'h10, wdata: 32'hFFFF_FFFF};
        rst_n = 1'b0;
        repeat (3) begin
            step();
            check_reset_state("rst1");
        end
        bus.mst_in.valid = 1'b0;
        rst_n = 1'b1;
        step();
        txn(1'b0, 32'h10, 32'h0, 32'h1234_5678, 1'b0, 1'b0);

        repeat (4) step();
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/slv_responder.md
Name: slv_responder

Overview:
- Slave-side endpoint of the master/slave bus. It sits behind one crossbar output: it accepts a t_mst request from the crossbar and returns a t_slv response.
- Holds a word-addressed local memory and executes single-beat reads and writes.
- Exports its protocol phase as t_st so the crossbar can time-share the slave between masters on same-half collisions. The crossbar switches at the CMD and ADDR phases.

Parameters:
- SLV_ID, 0, value of addr[31] this slave owns; a request with addr[31] != SLV_ID is answered with err.
- AW, 8, word-index width; memory depth is 2**AW 32-bit words.
- INIT_RDATA, 32'hDEAD_BEEF, rdata returned on error responses.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- mst_in  input  t_mst  request from crossbar: valid, we, addr[31:0], wdata[31:0].
- slv_out  output  t_slv  response to crossbar: ready, rvalid, rdata[31:0], err.
- st  output  t_st  current phase, for crossbar arbitration.

Behaviour:
- Reset, asynchronous, rst_n=0 (all values hold while low):
  - st=IDLE
  - slv_out.ready=1, rvalid=0, err=0, rdata=0
  - internal address/data/we registers = 0
  - memory contents are not reset.
- FSM, one transition per clk; t_st = {IDLE, CMD, ADDR, DATA, RESP}:
  - IDLE: ready=1. If mst_in.valid=1, capture we/addr/wdata and go to CMD (ready=0 next cycle). Otherwise stay in IDLE.
  - CMD: latch the command type and go to ADDR. mst_in is ignored from here until IDLE is re-entered.
  - ADDR: decode. bad = (addr[31]!=SLV_ID) OR (addr[30:AW+2] != 0) OR (addr[1:0] != 0). Compute word index = addr[AW+1:2]. Go to DATA.
  - DATA:
    - If !bad and we: write wdata to mem[index].
    - If !bad and !we: issue the RAM read.
    - If bad: no memory access.
    - Go to RESP.
  - RESP:
    - rvalid=1 for exactly one cycle.
    - rdata = RAM read data (read), wdata echo (write), or INIT_RDATA (bad).
    - err = bad.
    - Go to IDLE; ready=1 on the following cycle.
- Latency: valid sampled in IDLE at edge N → rvalid high during the cycle after edge N+4. Sustained throughput is one transaction per 5 cycles.
- ready is a registered output. It is 1 only in IDLE.
- valid while not in IDLE is dropped silently. The master must wait for ready.
- Read-after-write to the same word in back-to-back transactions returns the new data; the RAM write has completed before the next DATA phase.
- rdata and err hold their last value outside RESP. Only rvalid qualifies them.
- Reset asserted mid-transaction: abort to IDLE with no response. A write whose DATA edge had not occurred is not performed.
- Index wrap: none. The upper address bits must be zero, otherwise err.

Decomposition:
- Existing packages are extended, not duplicated:
  - pkg_mst: t_mst fields valid, we, addr, wdata.
  - pkg_slv: t_slv fields ready, rvalid, rdata, err.
  - pkg_st: t_st enumeration; IDLE, DATA and RESP are added alongside CMD and ADDR.
- Sub-module slv_ram: single-port synchronous RAM with parameter AW; 1-cycle read latency, write-first. Instantiated once.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles with valid=1 → st=IDLE, ready=1, rvalid=0, memory untouched. After release, the first valid is accepted.
- Write then read, SLV_ID=0:
  - Write addr=0x0000_0010, wdata=0x1234_5678 → rvalid on the 5th cycle, rdata=0x1234_5678, err=0.
  - Then read 0x0000_0010 → rdata=0x1234_5678, err=0.
  - st sequence is IDLE,CMD,ADDR,DATA,RESP,IDLE.
- Wrong slave: SLV_ID=0, write to 0x8000_0010 → err=1, rdata=0xDEAD_BEEF. A subsequent read of 0x0000_0010 is unchanged.
- Misaligned or out of range:
  - Read 0x0000_0012 → err=1.
  - Read 0x0000_0400 with AW=8 → err=1.
  - No memory access in either case.
- Busy drop: assert valid in CMD with write 0x0000_0020/0xAAAA_AAAA → ignored. mem[8] is unchanged and only one rvalid occurs.
- Mid-op reset: pulse rst_n low during CMD of a write to 0x0000_0030 → no rvalid, mem[12] retains its prior value, st=IDLE.
